psw_ctx: RTL

//  Parametrised program status word with an interrupt context stack.

---
 rtl/psw_ctx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/psw_ctx.sv
// Program status word (CY AC F0 RS1 RS0 OV F1 P) with a LIFO interrupt context stack.
// Optional feature: define PSW_CTX_AUTOBANK_EN to switch the register bank to the new nesting level on push.
module psw_ctx #(
    parameter  int ACC_W     = 8,
    parameter  int CTX_DEPTH = 2,
    localparam int LVL_W     = $clog2(CTX_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             carry_in,
    input  logic             aux_carry_in,
    input  logic             overflow_in,
    input  logic [ACC_W-1:0] acc_in,
    input  logic [1:0]       flag_set,
    input  logic             write_en,
    input  logic             write_bit_en,
    input  logic [2:0]       bit_addr,
    input  logic             bit_in,
    input  logic [7:0]       data_in,
    input  logic             ctx_push,
    input  logic             ctx_pop,
    output logic [7:0]       psw_data,
    output logic [LVL_W-1:0] ctx_level,
    output logic             ctx_full,
    output logic             ctx_empty,
    output logic             ctx_err
);

    // Stack is sized to the full level index range so ctx_level can address it directly.
    localparam int               STK_N    = 1 << LVL_W;
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1'b1);
    localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(1'b0);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(CTX_DEPTH);

    function automatic logic parity_f(input logic [ACC_W-1:0] value);
        return ^value;
    endfunction

    logic [7:0]       psw_r;
    logic [LVL_W-1:0] ctx_level_r;
    logic             ctx_err_r;
    logic [6:0]       stack_r [STK_N];

    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             err_s;
    logic [7:0]       psw_nxt_s;
    logic             data_in_unused_s;

    assign data_in_unused_s = data_in[0];

    assign full_s    = (ctx_level_r == LVL_MAX);
    assign empty_s   = (ctx_level_r == LVL_ZERO);
    assign push_ok_s = ctx_push & ~ctx_pop & ~full_s;
    assign pop_ok_s  = ctx_pop & ~ctx_push & ~empty_s;
    assign err_s     = (ctx_push & ctx_pop) | (ctx_push & ~ctx_pop & full_s) | (ctx_pop & ~ctx_push & empty_s);

`ifdef PSW_CTX_AUTOBANK_EN
    logic [LVL_W:0]   lvl_inc_s;
    logic [1:0]       bank_s;

    assign lvl_inc_s = {1'b0, ctx_level_r} + {{LVL_W{1'b0}}, 1'b1};
    assign bank_s    = lvl_inc_s[1:0];
`endif

    // Next PSW: pop restore beats byte write, beats bit write, beats ALU flag update.
    always_comb begin
        psw_nxt_s = psw_r;
        if (pop_ok_s) begin
            psw_nxt_s[7:1] = stack_r[ctx_level_r - LVL_ONE];
        end else if (write_en && !write_bit_en) begin
            psw_nxt_s[7:1] = data_in[7:1];
        end else if (write_en && write_bit_en) begin
            if (bit_addr != 3'd0) begin
                psw_nxt_s[bit_addr] = bit_in;
            end else begin
                psw_nxt_s = psw_r;
            end
        end else begin
            case (flag_set)
                2'b01: begin
                    psw_nxt_s[7] = carry_in;
                end
                2'b10: begin
                    psw_nxt_s[7] = carry_in;
                    psw_nxt_s[2] = overflow_in;
                end
                2'b11: begin
                    psw_nxt_s[7] = carry_in;
                    psw_nxt_s[6] = aux_carry_in;
                    psw_nxt_s[2] = overflow_in;
                end
                default: begin
                    psw_nxt_s = psw_r;
                end
            endcase
        end
`ifdef PSW_CTX_AUTOBANK_EN
        // The bank select follows the nesting depth, overriding any software write this cycle.
        if (push_ok_s) begin
            psw_nxt_s[4:3] = bank_s;
        end else begin
            psw_nxt_s[4:3] = psw_nxt_s[4:3];
        end
`endif
        psw_nxt_s[0] = parity_f(acc_in);
    end

    // PSW, nesting level, context stack and error pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            psw_r       <= 8'h00;
            ctx_level_r <= LVL_ZERO;
            ctx_err_r   <= 1'b0;
            for (int i = 0; i < STK_N; i++) begin
                stack_r[i] <= 7'h00;
            end
        end else begin
            psw_r     <= psw_nxt_s;
            ctx_err_r <= err_s;
            if (push_ok_s) begin
                stack_r[ctx_level_r] <= psw_r[7:1];
                ctx_level_r          <= ctx_level_r + LVL_ONE;
            end else if (pop_ok_s) begin
                ctx_level_r <= ctx_level_r - LVL_ONE;
            end else begin
                ctx_level_r <= ctx_level_r;
            end
        end
    end

    assign psw_data  = psw_r;
    assign ctx_level = ctx_level_r;
    assign ctx_full  = full_s;
    assign ctx_empty = empty_s;
    assign ctx_err   = ctx_err_r;

endmodule
